// File: rtl/ir_ac_frame_rx_pkg.sv
// rtl/ir_ac_frame_rx_pkg.sv - shared types, field widths and IR timing constants (us) for the AC remote frame
package ir_ac_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        CONN_SPACE = 3'd5,
        DONE       = 3'd6
    } ir_state_e;

    localparam int W35 = 35;
    localparam int W32 = 32;

    localparam int CLK_DIV_DEF    = 100;
    localparam int GLITCH_CYC_DEF = 200;

    // Nominal on-air timing, shared with the transmitter
    localparam logic [14:0] NOM_LEAD_MARK_US  = 15'd9000;
    localparam logic [14:0] NOM_LEAD_SPACE_US = 15'd4500;
    localparam logic [14:0] NOM_MARK_US       = 15'd600;
    localparam logic [14:0] NOM_ZERO_US       = 15'd600;
    localparam logic [14:0] NOM_ONE_US        = 15'd1690;
    localparam logic [14:0] NOM_CONN_US       = 15'd20000;

    // Receiver acceptance windows, inclusive
    localparam logic [14:0] LEAD_MARK_MIN_US  = 15'd8000;
    localparam logic [14:0] LEAD_MARK_MAX_US  = 15'd10000;
    localparam logic [14:0] LEAD_SPACE_MIN_US = 15'd4000;
    localparam logic [14:0] LEAD_SPACE_MAX_US = 15'd5000;
    localparam logic [14:0] MARK_MIN_US       = 15'd300;
    localparam logic [14:0] MARK_MAX_US       = 15'd900;
    localparam logic [14:0] ZERO_MIN_US       = 15'd300;
    localparam logic [14:0] ZERO_MAX_US       = 15'd900;
    localparam logic [14:0] ONE_MIN_US        = 15'd1300;
    localparam logic [14:0] ONE_MAX_US        = 15'd2000;
    localparam logic [14:0] CONN_MIN_US       = 15'd18000;
    localparam logic [14:0] CONN_MAX_US       = 15'd22000;

    function automatic logic in_win(input logic [14:0] d, input logic [14:0] lo, input logic [14:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_ac_frame_rx_if.sv
// rtl/ir_ac_frame_rx_if.sv - IR line input and decoded frame outputs of the AC frame receiver
interface ir_ac_frame_rx_if;
    import ir_ac_pkg::*;

    logic           ir_in;
    logic [W35-1:0] data35;
    logic [W32-1:0] data32;
    logic           frame_valid;
    logic           frame_err;
    logic           busy;
    logic           led;

    modport master (
        output ir_in,
        input  data35, data32, frame_valid, frame_err, busy, led
    );

    modport slave (
        input  ir_in,
        output data35, data32, frame_valid, frame_err, busy, led
    );
endinterface

// File: rtl/ir_ac_frame_rx_edge_detect.sv
// rtl/ir_ac_frame_rx_edge_detect.sv - IR line synchronizer, optional glitch filter (IR_GLITCH_FILTER_EN), edge strobes
module ir_edge_detect
    import ir_ac_pkg::*;
`ifdef IR_GLITCH_FILTER_EN
#(
    parameter int GLITCH_CYC = GLITCH_CYC_DEF
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic rise,
    output logic fall
);
    logic s1;
    logic s2;
    logic line;
    logic line_q;

    // Two-flop synchronizer; idle line is high (space)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= ir_in;
            s2 <= s1;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    localparam int GW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
    logic [GW-1:0] gcnt;

    // Accept a new level only after it has been stable for GLITCH_CYC clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= 1'b1;
            gcnt <= '0;
        end else if (s2 == line) begin
            gcnt <= '0;
        end else if (gcnt == GW'(GLITCH_CYC - 1)) begin
            line <= s2;
            gcnt <= '0;
        end else begin
            gcnt <= gcnt + 1'b1;
        end
    end
`else
    assign line = s2;
`endif

    // Previous line level for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= 1'b1;
        end else begin
            line_q <= line;
        end
    end

    assign rise = line & ~line_q;
    assign fall = ~line & line_q;
endmodule

// File: rtl/ir_ac_frame_rx.sv
// rtl/ir_ac_frame_rx.sv - AC remote IR frame receiver (leader, 35 bits, connect, 32 bits); IR_GLITCH_FILTER_EN enables the line filter
module ir_ac_frame_rx
    import ir_ac_pkg::*;
#(
`ifdef IR_GLITCH_FILTER_EN
    parameter int          GLITCH_CYC     = GLITCH_CYC_DEF,
`endif
    parameter int          CLK_DIV        = CLK_DIV_DEF,
    parameter logic [14:0] LEAD_MARK_MIN  = LEAD_MARK_MIN_US,
    parameter logic [14:0] LEAD_MARK_MAX  = LEAD_MARK_MAX_US,
    parameter logic [14:0] LEAD_SPACE_MIN = LEAD_SPACE_MIN_US,
    parameter logic [14:0] LEAD_SPACE_MAX = LEAD_SPACE_MAX_US,
    parameter logic [14:0] MARK_MIN       = MARK_MIN_US,
    parameter logic [14:0] MARK_MAX       = MARK_MAX_US,
    parameter logic [14:0] ZERO_MIN       = ZERO_MIN_US,
    parameter logic [14:0] ZERO_MAX       = ZERO_MAX_US,
    parameter logic [14:0] ONE_MIN        = ONE_MIN_US,
    parameter logic [14:0] ONE_MAX        = ONE_MAX_US,
    parameter logic [14:0] CONN_MIN       = CONN_MIN_US,
    parameter logic [14:0] CONN_MAX       = CONN_MAX_US
) (
    input  logic            clk,
    input  logic            rst,
    ir_ac_frame_rx_if.slave rx
);
    localparam logic [2:0] ST_IDLE       = IDLE;
    localparam logic [2:0] ST_LEAD_MARK  = LEAD_MARK;
    localparam logic [2:0] ST_LEAD_SPACE = LEAD_SPACE;
    localparam logic [2:0] ST_BIT_MARK   = BIT_MARK;
    localparam logic [2:0] ST_BIT_SPACE  = BIT_SPACE;
    localparam logic [2:0] ST_CONN_SPACE = CONN_SPACE;
    localparam logic [2:0] ST_DONE       = DONE;

    localparam int          DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [14:0] CNT_SAT   = 15'h7fff;
    localparam logic [14:0] SPACE_MAX = (ONE_MAX > ZERO_MAX) ? ONE_MAX : ZERO_MAX;

    logic             rise;
    logic             fall;
    logic [2:0]       state;
    logic [2:0]       state_n;
    logic             err;
    logic [DIV_W-1:0] div;
    logic [14:0]      cnt;
    logic [5:0]       bitcnt;
    logic             field;
    logic [W35-1:0]   sr35;
    logic [W32-1:0]   sr32;
    logic [W35-1:0]   data35;
    logic [W32-1:0]   data32;
    logic             frame_valid;
    logic             frame_err;
    logic             busy;
    logic             led;
    logic             bit_zero;
    logic             bit_one;

    ir_edge_detect
`ifdef IR_GLITCH_FILTER_EN
        #(.GLITCH_CYC(GLITCH_CYC))
`endif
    u_edge (
        .clk   (clk),
        .rst   (rst),
        .ir_in (rx.ir_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign bit_zero = in_win(cnt, ZERO_MIN, ZERO_MAX);
    assign bit_one  = in_win(cnt, ONE_MIN, ONE_MAX);

    // Next state: each edge classifies the pulse that just ended; overrun of the state's max is a timeout
    always_comb begin
        state_n = state;
        err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) state_n = ST_LEAD_MARK;
            end
            ST_LEAD_MARK: begin
                if (rise) begin
                    if (in_win(cnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_n = ST_LEAD_SPACE;
                    else err = 1'b1;
                end else if (cnt > LEAD_MARK_MAX) begin
                    err = 1'b1;
                end
            end
            ST_LEAD_SPACE: begin
                if (fall) begin
                    if (in_win(cnt, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) state_n = ST_BIT_MARK;
                    else err = 1'b1;
                end else if (cnt > LEAD_SPACE_MAX) begin
                    err = 1'b1;
                end
            end
            ST_BIT_MARK: begin
                if (rise) begin
                    if (!in_win(cnt, MARK_MIN, MARK_MAX)) err = 1'b1;
                    else if (!field && bitcnt == 6'(W35)) state_n = ST_CONN_SPACE;
                    else if (field && bitcnt == 6'(W32)) state_n = ST_DONE;
                    else state_n = ST_BIT_SPACE;
                end else if (cnt > MARK_MAX) begin
                    err = 1'b1;
                end
            end
            ST_BIT_SPACE: begin
                if (fall) begin
                    if (bit_zero || bit_one) state_n = ST_BIT_MARK;
                    else err = 1'b1;
                end else if (cnt > SPACE_MAX) begin
                    err = 1'b1;
                end
            end
            ST_CONN_SPACE: begin
                if (fall) begin
                    if (in_win(cnt, CONN_MIN, CONN_MAX)) state_n = ST_BIT_MARK;
                    else err = 1'b1;
                end else if (cnt > CONN_MAX) begin
                    err = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (err) state_n = ST_IDLE;
    end

    // 1 us prescaler and saturating duration counter, restarted on every edge and state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            cnt <= '0;
        end else if (rise || fall || (state_n != state)) begin
            div <= '0;
            cnt <= '0;
        end else if (div == DIV_W'(CLK_DIV - 1)) begin
            div <= '0;
            if (cnt != CNT_SAT) cnt <= cnt + 15'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // State register plus registered status/pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
            led         <= 1'b0;
            data35      <= '0;
            data32      <= '0;
        end else begin
            state       <= state_n;
            busy        <= (state_n != ST_IDLE);
            frame_err   <= err;
            frame_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                data35 <= sr35;
                data32 <= sr32;
                led    <= ~led;
            end
        end
    end

    // Bit counter, field select and MSB-first shift registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt <= '0;
            field  <= 1'b0;
            sr35   <= '0;
            sr32   <= '0;
        end else if (state == ST_LEAD_SPACE && state_n == ST_BIT_MARK) begin
            bitcnt <= '0;
            field  <= 1'b0;
        end else if (state == ST_CONN_SPACE && state_n == ST_BIT_MARK) begin
            bitcnt <= '0;
            field  <= 1'b1;
        end else if (state == ST_BIT_SPACE && state_n == ST_BIT_MARK) begin
            bitcnt <= bitcnt + 6'd1;
            if (field) sr32 <= {sr32[W32-2:0], bit_one};
            else       sr35 <= {sr35[W35-2:0], bit_one};
        end
    end

    assign rx.data35      = data35;
    assign rx.data32      = data32;
    assign rx.frame_valid = frame_valid;
    assign rx.frame_err   = frame_err;
    assign rx.busy        = busy;
    assign rx.led         = led;
endmodule

// File: tb/tb_ir_ac_frame_rx.sv
// tb/tb_ir_ac_frame_rx.sv - self-checking bench for ir_ac_frame_rx (time scaled: 1 clk per tick, windows / 20)
module tb_ir_ac_frame_rx;
    import ir_ac_pkg::*;

    localparam int LMMIN = 400, LMMAX = 500, LSMIN = 200, LSMAX = 250;
    localparam int MKMIN = 15,  MKMAX = 45,  ZMIN  = 15,  ZMAX  = 45;
    localparam int OMIN  = 65,  OMAX  = 100, CMIN  = 900, CMAX  = 1100;

    localparam int NOM_LM = int'(NOM_LEAD_MARK_US) / 20;
    localparam int NOM_LS = int'(NOM_LEAD_SPACE_US) / 20;
    localparam int NOM_MK = int'(NOM_MARK_US) / 20;
    localparam int NOM_ZR = int'(NOM_ZERO_US) / 20;
    localparam int NOM_ON = int'(NOM_ONE_US) / 20;
    localparam int NOM_CN = int'(NOM_CONN_US) / 20;

    localparam logic [34:0] NOM35 = 35'h5_A5A5_A5A5;
    localparam logic [31:0] NOM32 = 32'h1234_5678;

    logic clk;
    logic rst;
    int   cyc = 0, n_valid = 0, n_err = 0, n_both = 0, err_cyc = 0, start_cyc = 0;
    int   checks = 0, errors = 0;
    logic [34:0] exp35;
    logic [31:0] exp32;
    logic        exp_led;
    int          frm[$];

    ir_ac_frame_rx_if rx_if ();

    ir_ac_frame_rx #(
`ifdef IR_GLITCH_FILTER_EN
        .GLITCH_CYC     (4),
`endif
        .CLK_DIV        (1),
        .LEAD_MARK_MIN  (15'(LMMIN)), .LEAD_MARK_MAX  (15'(LMMAX)),
        .LEAD_SPACE_MIN (15'(LSMIN)), .LEAD_SPACE_MAX (15'(LSMAX)),
        .MARK_MIN       (15'(MKMIN)), .MARK_MAX       (15'(MKMAX)),
        .ZERO_MIN       (15'(ZMIN)),  .ZERO_MAX       (15'(ZMAX)),
        .ONE_MIN        (15'(OMIN)),  .ONE_MAX        (15'(OMAX)),
        .CONN_MIN       (15'(CMIN)),  .CONN_MAX       (15'(CMAX))
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            if (rx_if.frame_valid) n_valid++;
            if (rx_if.frame_err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (rx_if.frame_valid && rx_if.frame_err) n_both++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mark_d(input bit jit);
        return jit ? int'($urandom_range(40, 20)) : NOM_MK;
    endfunction

    function automatic int space_d(input bit one, input bit jit);
        if (one) return jit ? int'($urandom_range(95, 70)) : NOM_ON;
        return jit ? int'($urandom_range(40, 20)) : NOM_ZR;
    endfunction

    // Frame on air as alternating durations, starting with the leader mark
    task automatic build(input logic [34:0] a, input logic [31:0] b, input bit jit);
        frm.delete();
        frm.push_back(jit ? int'($urandom_range(470, 430)) : NOM_LM);
        frm.push_back(jit ? int'($urandom_range(235, 215)) : NOM_LS);
        for (int i = 34; i >= 0; i--) begin
            frm.push_back(mark_d(jit));
            frm.push_back(space_d(a[i], jit));
        end
        frm.push_back(mark_d(jit));
        frm.push_back(jit ? int'($urandom_range(1050, 950)) : NOM_CN);
        for (int i = 31; i >= 0; i--) begin
            frm.push_back(mark_d(jit));
            frm.push_back(space_d(b[i], jit));
        end
        frm.push_back(mark_d(jit));
    endtask

    function automatic bit in_rng(input int m, input int lo, input int hi);
        return (m >= lo) && (m <= hi);
    endfunction

    // Reference: index of the first pulse whose measured length (cycles - 1) breaks its window, -1 if none
    function automatic int first_bad();
        for (int i = 0; i < frm.size(); i++) begin
            int m;
            bit good;
            m = frm[i] - 1;
            if (i == 0)          good = in_rng(m, LMMIN, LMMAX);
            else if (i == 1)     good = in_rng(m, LSMIN, LSMAX);
            else if (i == 73)    good = in_rng(m, CMIN, CMAX);
            else if (i % 2 == 0) good = in_rng(m, MKMIN, MKMAX);
            else                 good = in_rng(m, ZMIN, ZMAX) || in_rng(m, OMIN, OMAX);
            if (!good) return i;
        end
        return -1;
    endfunction

    task automatic send(input int last);
        start_cyc = cyc;
        for (int i = 0; i <= last; i++) begin
            rx_if.ir_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (frm[i]) @(negedge clk);
        end
        if (last % 2 == 1) begin
            rx_if.ir_in = 1'b0;
            repeat (30) @(negedge clk);
        end
        rx_if.ir_in = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data35"}, 64'(rx_if.data35), 64'(exp35));
        check({tag, ".data32"}, 64'(rx_if.data32), 64'(exp32));
        check({tag, ".led"},    64'(rx_if.led),    64'(exp_led));
        check({tag, ".busy"},   64'(rx_if.busy),   64'd0);
    endtask

    task automatic run_case(input string tag, input logic [34:0] a, input logic [31:0] b);
        int bad, v0, e0;
        bad = first_bad();
        v0  = n_valid;
        e0  = n_err;
        send((bad < 0) ? frm.size() - 1 : bad);
        if (bad < 0) begin
            exp35   = a;
            exp32   = b;
            exp_led = ~exp_led;
        end
        check({tag, ".valid"}, 64'(n_valid - v0), (bad < 0) ? 64'd1 : 64'd0);
        check({tag, ".err"},   64'(n_err - e0),   (bad < 0) ? 64'd0 : 64'd1);
        check_outputs(tag);
    endtask

    initial begin
        logic [63:0] r;
        logic [34:0] ra;
        logic [31:0] rb;
        int v0, e0;

        rx_if.ir_in = 1'b1;
        rst = 1'b0;
        exp35 = '0;
        exp32 = '0;
        exp_led = 1'b0;
        repeat (5) @(negedge clk);
        check("rst.valid", 64'(rx_if.frame_valid), 64'd0);
        check("rst.err",   64'(rx_if.frame_err),   64'd0);
        check_outputs("rst");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle.busy", 64'(rx_if.busy), 64'd0);

        build(NOM35, NOM32, 1'b0);
        run_case("nominal", NOM35, NOM32);

        build(NOM35, NOM32, 1'b0);
        frm[0] = 350;
        run_case("lead_short", NOM35, NOM32);

        build(NOM35, NOM32, 1'b0);
        run_case("nominal2", NOM35, NOM32);

        build(NOM35, NOM32, 1'b0);
        frm[23] = 55;
        run_case("bit10_space", NOM35, NOM32);

        build(NOM35, NOM32, 1'b0);
        frm[0] = 600;
        run_case("lead_timeout", NOM35, NOM32);
        check("lead_timeout.when",
              64'(in_rng(err_cyc - start_cyc, LMMAX + 1, LMMAX + 12)), 64'd1);

        build(NOM35, NOM32, 1'b0);
        v0 = n_valid;
        e0 = n_err;
        rx_if.ir_in = 1'b0;
        repeat (frm[0]) @(negedge clk);
        rx_if.ir_in = 1'b1;
        repeat (100) @(negedge clk);
        check("mid.busy", 64'(rx_if.busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        exp35   = '0;
        exp32   = '0;
        exp_led = 1'b0;
        check_outputs("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check("async_rst.valid", 64'(n_valid - v0), 64'd0);
        check("async_rst.err",   64'(n_err - e0),   64'd0);

        for (int k = 0; k < 2; k++) begin
            r  = {$urandom, $urandom};
            ra = r[34:0];
            rb = $urandom;
            build(ra, rb, 1'b1);
            run_case($sformatf("rand%0d", k), ra, rb);
        end

        build(NOM35, NOM32, 1'b0);
        v0 = n_valid;
        e0 = n_err;
        rx_if.ir_in = 1'b0;
        repeat (220) @(negedge clk);
        rx_if.ir_in = 1'b1;
        repeat (2) @(negedge clk);
        frm[0] = 228;
`ifdef IR_GLITCH_FILTER_EN
        send(frm.size() - 1);
        exp35   = NOM35;
        exp32   = NOM32;
        exp_led = ~exp_led;
        check("glitch.valid", 64'(n_valid - v0), 64'd1);
        check("glitch.err",   64'(n_err - e0),   64'd0);
`else
        send(0);
        check("glitch.valid", 64'(n_valid - v0), 64'd0);
        check("glitch.err",   64'((n_err - e0) >= 1), 64'd1);
`endif
        check_outputs("glitch");

        check("valid_err_overlap", 64'(n_both), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_ac_frame_rx.md
Name: ir_ac_frame_rx

Overview:
Infrared receiver for the air-conditioner remote frame. Decodes the demodulated IR receiver output (carrier already stripped, mark = low) into a 35-bit and a 32-bit payload. Frame on air: leader, 35 bits, connect code, 32 bits, trailing mark. Sits beside the IR transmitter so the board can loop back its own frames and learn codes from an original remote.

Parameters:
CLK_DIV, 100, clk cycles per 1 us tick (100 MHz clock)
LEAD_MARK_MIN/MAX, 8000/10000, leader mark window in us (nominal 9000)
LEAD_SPACE_MIN/MAX, 4000/5000, leader space window in us (nominal 4500)
MARK_MIN/MAX, 300/900, bit, connect and trailing mark window in us (nominal 600)
ZERO_MIN/MAX, 300/900, bit-0 space window in us
ONE_MIN/MAX, 1300/2000, bit-1 space window in us
CONN_MIN/MAX, 18000/22000, connect space window in us (nominal 20000)
GLITCH_CYC, 200, stable cycles required by the optional filter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
ir_in  in  1  raw IR receiver output, asynchronous, low = mark
data35  out  35  last good first field, bit 34 = first received
data32  out  32  last good second field, bit 31 = first received
frame_valid  out  1  one-cycle pulse when data35/data32 update
frame_err  out  1  one-cycle pulse on any protocol or timing violation
busy  out  1  high whenever state is not IDLE
led  out  1  toggles on each frame_valid

Behaviour:
- Reset (rst = 0), all outputs 0: data35, data32, frame_valid, frame_err, busy, led. State IDLE. Line sampled value = 1 (space).
- ir_in passes through a 2-FF synchronizer. An edge is a change of the synchronized, optionally filtered, line.
- Prescaler produces a 1 us tick. A 15-bit duration counter:
  - counts ticks, saturating at 32767;
  - clears on every edge and on every state entry.
- Each edge classifies the pulse that just ended: dur = counter value at that edge, checked against inclusive windows.
- States and transitions:
  - IDLE: falling edge -> LEAD_MARK.
  - LEAD_MARK: rising edge with dur in the leader-mark window -> LEAD_SPACE.
  - LEAD_SPACE: falling edge with dur in the leader-space window -> BIT_MARK; bitcnt = 0; field = 0.
  - BIT_MARK: rising edge with dur in the mark window, then:
    - field = 0 and bitcnt = 35 -> CONN_SPACE;
    - field = 1 and bitcnt = 32 -> DONE;
    - otherwise -> BIT_SPACE.
  - BIT_SPACE: falling edge. dur in the zero window shifts in 0; dur in the one window shifts in 1. Then bitcnt += 1 -> BIT_MARK. Shift target is sr35 when field = 0, sr32 when field = 1 (MSB-first, shift left).
  - CONN_SPACE: falling edge with dur in the connect window -> BIT_MARK; field = 1; bitcnt = 0.
  - DONE (1 cycle): data35 <= sr35, data32 <= sr32, frame_valid = 1, led toggles -> IDLE.
- Error rules, each giving a frame_err pulse and a return to IDLE:
  - dur outside the window at any classifying edge;
  - counter exceeding the current state's MAX before the edge arrives (timeout; fires the cycle the counter reaches MAX+1).
- After an error, data35/data32 hold their previous values; a partial frame never reaches the outputs.
- After an error the line may still be low. IDLE waits for a falling edge, so a mark already in progress is ignored.
- frame_valid and frame_err are never high in the same cycle.
- busy = (state != IDLE) and is registered.
- Async reset mid-frame: immediate return to reset values; no pulses emitted.
- Latency: frame_valid asserts 2 cycles after the synchronized trailing-mark rising edge. Add 2 cycles for the synchronizer, plus GLITCH_CYC when the filter is enabled.

Optional Feature:
IR_GLITCH_FILTER_EN
- Defined: the synchronized line updates only after ir_in has held a new level for GLITCH_CYC consecutive clocks. Pulses shorter than 2 us are ignored. All measured durations shift equally, so the windows are unchanged.
- Undefined: the synchronized line is used directly; a glitch during a mark or space produces a window error.

Decomposition:
- Package ir_ac_pkg holds:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CONN_SPACE, DONE);
  - field widths (35, 32);
  - the nominal timing constants in us, shared with the transmitter.
- One sub-module, ir_edge_detect: synchronizer, optional glitch filter, and rise/fall strobes.

Test Plan:
- Reset with ir_in = 1 -> all outputs 0, busy = 0.
- Nominal frame: data35 = 35'h5_A5A5_A5A5, data32 = 32'h1234_5678, marks 600 us, spaces 600/1690, connect 20000 -> one frame_valid; outputs match; led = 1.
- Leader mark 7000 us -> frame_err on the rising edge; outputs unchanged; next nominal frame decodes.
- Bit space 1100 us at bit 10 of field 0 -> frame_err; data outputs unchanged.
- Line held low 12 ms after leader start -> frame_err when the counter reaches 10001.
- With IR_GLITCH_FILTER_EN, a 0.5 us high glitch inside a 9 ms leader mark -> frame still valid; without it -> frame_err.
